// File: rtl/gbt_tx_frame_packer.sv
// Packs 16-bit words into 84-bit GBT TX frames (type, seq, 64-bit payload, CRC-8).
// Optional macro GBT_TX_PACKER_CRC_EN enables the CRC-8 field; otherwise frame_o[7:0] is 8'h00.
module gbt_tx_frame_packer #(
  parameter logic [63:0] IDLE_PATTERN = 64'h0,
  parameter int          SEQ_W        = 8
) (
  input  logic        clk_40mhz,
  input  logic        reset_n,
  input  logic        link_ready_i,
  input  logic [15:0] word_i,
  input  logic        word_valid_i,
  input  logic        word_last_i,
  output logic        word_ready_o,
  output logic [83:0] frame_o,
  output logic        frame_is_data_o,
  output logic [31:0] frame_cnt_o
);

  localparam logic [1:0] TYPE_IDLE  = 2'b00;
  localparam logic [1:0] TYPE_FULL  = 2'b01;
  localparam logic [1:0] TYPE_SHORT = 2'b10;

`ifdef GBT_TX_PACKER_CRC_EN
  // CRC-8, poly 0x07, init 0, MSB first over the 76 header+payload bits
  function automatic logic [7:0] crc8(input logic [75:0] hdr);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = 75; i >= 0; i--) begin
      fb = c[7] ^ hdr[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction
`endif

  function automatic logic [83:0] make_frame(input logic [75:0] hdr);
`ifdef GBT_TX_PACKER_CRC_EN
    return {hdr, crc8(hdr)};
`else
    return {hdr, 8'h00};
`endif
  endfunction

  localparam logic [83:0] RESET_FRAME = make_frame({TYPE_IDLE, 2'b00, 8'h00, IDLE_PATTERN});

  logic [1:0]       count_q, count_d;
  logic [15:0]      slot_q [4];
  logic [15:0]      slot_d [4];
  logic             pend_valid_q, pend_valid_d;
  logic [1:0]       pend_type_q, pend_type_d;
  logic [1:0]       pend_cnt_q, pend_cnt_d;
  logic [63:0]      pend_payload_q, pend_payload_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [83:0]      frame_q, frame_d;
  logic             frame_is_data_q, frame_is_data_d;
  logic [31:0]      frame_cnt_q, frame_cnt_d;
  logic             accept;
  logic             drain;

  assign word_ready_o    = !pend_valid_q || link_ready_i;
  assign accept          = word_valid_i && word_ready_o;
  assign drain           = link_ready_i && pend_valid_q;
  assign frame_o         = frame_q;
  assign frame_is_data_o = frame_is_data_q;
  assign frame_cnt_o     = frame_cnt_q;

  // A draining pending frame may be replaced by a newly closed one on the same edge
  always_comb begin
    count_d        = count_q;
    slot_d         = slot_q;
    pend_valid_d   = pend_valid_q && !drain;
    pend_type_d    = pend_type_q;
    pend_cnt_d     = pend_cnt_q;
    pend_payload_d = pend_payload_q;
    if (accept) begin
      slot_d[count_q] = word_i;
      if (count_q == 2'd3 || word_last_i) begin
        pend_valid_d = 1'b1;
        pend_type_d  = (count_q == 2'd3) ? TYPE_FULL : TYPE_SHORT;
        pend_cnt_d   = count_q;
        for (int i = 0; i < 4; i++) begin
          pend_payload_d[63-16*i -: 16] = (2'(i) <= count_q) ? slot_d[i] : 16'h0000;
        end
        count_d = 2'd0;
      end else begin
        count_d = count_q + 2'd1;
      end
    end
  end

  always_comb begin
    seq_d       = seq_q;
    frame_cnt_d = frame_cnt_q;
    if (drain) begin
      frame_d         = make_frame({pend_type_q, pend_cnt_q, seq_q, pend_payload_q});
      frame_is_data_d = 1'b1;
      seq_d           = seq_q + SEQ_W'(1);
      frame_cnt_d     = frame_cnt_q + 32'd1;
    end else begin
      frame_d         = make_frame({TYPE_IDLE, 2'b00, seq_q, IDLE_PATTERN});
      frame_is_data_d = 1'b0;
    end
  end

  always_ff @(posedge clk_40mhz or negedge reset_n) begin
    if (!reset_n) begin
      count_q         <= 2'd0;
      for (int i = 0; i < 4; i++) slot_q[i] <= 16'h0000;
      pend_valid_q    <= 1'b0;
      pend_type_q     <= TYPE_IDLE;
      pend_cnt_q      <= 2'd0;
      pend_payload_q  <= 64'h0;
      seq_q           <= '0;
      frame_q         <= RESET_FRAME;
      frame_is_data_q <= 1'b0;
      frame_cnt_q     <= 32'd0;
    end else begin
      count_q         <= count_d;
      slot_q          <= slot_d;
      pend_valid_q    <= pend_valid_d;
      pend_type_q     <= pend_type_d;
      pend_cnt_q      <= pend_cnt_d;
      pend_payload_q  <= pend_payload_d;
      seq_q           <= seq_d;
      frame_q         <= frame_d;
      frame_is_data_q <= frame_is_data_d;
      frame_cnt_q     <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_gbt_tx_frame_packer.sv
// Scoreboard bench for gbt_tx_frame_packer: expected frames are queued at word acceptance
// and compared when the DUT emits data; idle frames are checked against the tracked seq.
`timescale 1ns/1ps
module tb_gbt_tx_frame_packer;

   logic        clk_40mhz = 1'b0;
   logic        reset_n = 1'b0;
   logic        link_ready_i = 1'b0;
   logic [15:0] word_i = 16'h0;
   logic        word_valid_i = 1'b0;
   logic        word_last_i = 1'b0;
   logic        word_ready_o;
   logic [83:0] frame_o;
   logic        frame_is_data_o;
   logic [31:0] frame_cnt_o;

   typedef struct packed {
      logic [1:0]  typ;
      logic [1:0]  cnt;
      logic [63:0] payload;
   } exp_t;

   exp_t        expQ[$];
   int          testCount = 0;
   int          failCount = 0;
   logic [7:0]  expSeq = 8'h00;
   logic [31:0] expCnt = 32'd0;
   logic [15:0] modelWord [4];
   int          modelCount = 0;
   bit          monitorOn = 1'b0;
   bit          linkAtEdge = 1'b0;
   int          stallCount = 0;
   logic [31:0] startCnt;

   gbt_tx_frame_packer dut (
      .clk_40mhz(clk_40mhz),
      .reset_n(reset_n),
      .link_ready_i(link_ready_i),
      .word_i(word_i),
      .word_valid_i(word_valid_i),
      .word_last_i(word_last_i),
      .word_ready_o(word_ready_o),
      .frame_o(frame_o),
      .frame_is_data_o(frame_is_data_o),
      .frame_cnt_o(frame_cnt_o)
   );

   // 40 MHz frame clock
   always #12.5 clk_40mhz = ~clk_40mhz;

   // Remember whether the link was up at the edge that produced the visible frame
   always @(posedge clk_40mhz) linkAtEdge = link_ready_i;

   task automatic checkOutput(input string tag, input logic [83:0] observed, input logic [83:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Reference CRC as polynomial long division of the header shifted left by 8
   function automatic logic [7:0] refCrc(input logic [75:0] hdr);
      logic [83:0] r;
      r = {hdr, 8'h00};
      for (int i = 83; i >= 8; i--) begin
         if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
      end
      return r[7:0];
   endfunction

   function automatic logic [83:0] expFrame(input logic [1:0] typ, input logic [1:0] cnt,
                                            input logic [7:0] seq, input logic [63:0] payload);
      logic [75:0] hdr;
      hdr = {typ, cnt, seq, payload};
`ifdef GBT_TX_PACKER_CRC_EN
      return {hdr, refCrc(hdr)};
`else
      return {hdr, 8'h00};
`endif
   endfunction

   // Model of the word accumulator: closing a frame pushes its expectation
   task automatic modelAccept(input logic [15:0] w, input bit last);
      logic [63:0] payload;
      exp_t        e;
      modelWord[modelCount] = w;
      if (modelCount == 3 || last) begin
         payload = 64'h0;
         for (int k = 0; k <= modelCount; k++) payload = payload | (64'(modelWord[k]) << (16 * (3 - k)));
         e.typ     = (modelCount == 3) ? 2'b01 : 2'b10;
         e.cnt     = 2'(modelCount);
         e.payload = payload;
         expQ.push_back(e);
         modelCount = 0;
      end else begin
         modelCount++;
      end
   endtask

   // Offer one word and hold it until accepted, bounded by a cycle budget
   task automatic applyStimulus(input logic [15:0] w, input bit last);
      int waited;
      waited = 0;
      word_i       = w;
      word_last_i  = last;
      word_valid_i = 1'b1;
      #1;
      if (!word_ready_o) stallCount++;
      while (!word_ready_o && waited < 200) begin
         @(negedge clk_40mhz);
         #1;
         waited++;
      end
      if (!word_ready_o) begin
         checkOutput("acceptTimeout", 84'd0, 84'd1);
         word_valid_i = 1'b0;
         word_last_i  = 1'b0;
         return;
      end
      @(posedge clk_40mhz);
      modelAccept(w, last);
      @(negedge clk_40mhz);
      word_valid_i = 1'b0;
      word_last_i  = 1'b0;
   endtask

   // Wait until every expected frame has been emitted
   task automatic waitDrain();
      int n;
      n = 0;
      while (expQ.size() != 0 && n < 50) begin
         @(negedge clk_40mhz);
         n++;
      end
      checkOutput("drainDone", 84'(expQ.size()), 84'd0);
      @(negedge clk_40mhz);
   endtask

   // Monitor compares every frame away from the active edge
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_40mhz);
         if (monitorOn && reset_n) begin
            if (frame_is_data_o) begin
               checkOutput("dataLinkUp", 84'(linkAtEdge), 84'd1);
               if (expQ.size() == 0) begin
                  checkOutput("unexpectedData", 84'd1, 84'd0);
               end else begin
                  e = expQ.pop_front();
                  checkOutput("dataFrame", frame_o, expFrame(e.typ, e.cnt, expSeq, e.payload));
                  expSeq = expSeq + 8'd1;
                  expCnt = expCnt + 32'd1;
                  checkOutput("dataCount", 84'(frame_cnt_o), 84'(expCnt));
               end
            end else begin
               checkOutput("idleFrame", frame_o, expFrame(2'b00, 2'b00, expSeq, 64'h0));
               checkOutput("idleCount", 84'(frame_cnt_o), 84'(expCnt));
            end
         end
      end
   end

   // Hard stop in case something hangs
   initial begin
      #(25.0 * 20000);
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   // Main sequence: idle, single frames, streaming, link drop, async reset
   initial begin
      #30;
      checkOutput("resetFrame", frame_o, expFrame(2'b00, 2'b00, 8'h00, 64'h0));
      checkOutput("resetIsData", 84'(frame_is_data_o), 84'd0);
      checkOutput("resetCnt", 84'(frame_cnt_o), 84'd0);
      checkOutput("resetReady", 84'(word_ready_o), 84'd1);
      @(negedge clk_40mhz);
      reset_n      = 1'b1;
      link_ready_i = 1'b1;
      monitorOn    = 1'b1;
      repeat (10) @(negedge clk_40mhz);

      applyStimulus(16'h1111, 1'b0);
      applyStimulus(16'h2222, 1'b0);
      applyStimulus(16'h3333, 1'b0);
      applyStimulus(16'h4444, 1'b0);
      waitDrain();
      checkOutput("cntAfterFirst", 84'(frame_cnt_o), 84'd1);

      applyStimulus(16'hABCD, 1'b1);
      waitDrain();

      applyStimulus(16'h5551, 1'b0);
      applyStimulus(16'h5552, 1'b0);
      word_last_i = 1'b1;
      repeat (2) @(negedge clk_40mhz);
      word_last_i = 1'b0;
      applyStimulus(16'h5553, 1'b0);
      applyStimulus(16'h5554, 1'b0);
      waitDrain();

      stallCount = 0;
      startCnt   = frame_cnt_o;
      for (int i = 0; i < 1200; i++) applyStimulus(16'($urandom), 1'b0);
      waitDrain();
      checkOutput("streamStalls", 84'(stallCount), 84'd0);
      checkOutput("streamCnt", 84'(frame_cnt_o), 84'(startCnt + 32'd300));

      link_ready_i = 1'b0;
      applyStimulus(16'hA001, 1'b0);
      applyStimulus(16'hA002, 1'b0);
      applyStimulus(16'hA003, 1'b0);
      applyStimulus(16'hA004, 1'b0);
      #1;
      checkOutput("readyLowStall", 84'(word_ready_o), 84'd0);
      fork
         applyStimulus(16'hB001, 1'b0);
         begin
            repeat (6) @(negedge clk_40mhz);
            checkOutput("readyStillLow", 84'(word_ready_o), 84'd0);
            link_ready_i = 1'b1;
         end
      join
      applyStimulus(16'hB002, 1'b0);
      applyStimulus(16'hB003, 1'b1);
      waitDrain();

      applyStimulus(16'hC001, 1'b0);
      applyStimulus(16'hC002, 1'b0);
      #7;
      reset_n   = 1'b0;
      monitorOn = 1'b0;
      #1;
      checkOutput("midResetFrame", frame_o, expFrame(2'b00, 2'b00, 8'h00, 64'h0));
      checkOutput("midResetIsData", 84'(frame_is_data_o), 84'd0);
      checkOutput("midResetCnt", 84'(frame_cnt_o), 84'd0);
      checkOutput("midResetReady", 84'(word_ready_o), 84'd1);
      modelCount = 0;
      expQ.delete();
      expSeq = 8'h00;
      expCnt = 32'd0;
      @(negedge clk_40mhz);
      reset_n   = 1'b1;
      monitorOn = 1'b1;
      repeat (2) @(negedge clk_40mhz);
      applyStimulus(16'hD001, 1'b1);
      waitDrain();
      checkOutput("cntAfterReset", 84'(frame_cnt_o), 84'd1);

      repeat (3) @(negedge clk_40mhz);
      monitorOn = 1'b0;
      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
